// File: rtl/sha256_axi_sequencer.sv
// sha256_axi_sequencer
//   AXI4-Lite master that feeds 512-bit message blocks (sixteen 32-bit words)
//   into the sha256_v1_0 IP. It pulses the init/next control bits and polls
//   status until the digest is valid. It then streams the 256-bit digest back
//   out as eight words.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_word/in_first          block word stream (valid/ready), first-block flag
//   dig_word/dig_last         digest word stream (valid/ready), H0 first
//   busy, err                 not-idle indicator, sticky error flag
//   write_* / read_*          AXI4-Lite AW, W, B, AR and R channels
//
// Only one AXI transaction is outstanding at a time. Every output comes
// straight from a register, or is a constant.
module sha256_axi_sequencer #(
    parameter logic [31:0] ADDR_CTRL   = 32'd4,
    parameter logic [31:0] ADDR_STATUS = 32'd8,
    parameter logic [31:0] ADDR_BLOCK  = 32'd20,
    parameter logic [31:0] ADDR_DIGEST = 32'd84,
    parameter int          POLL_LIMIT  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] in_word,
    input  logic        in_first,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] dig_word,
    output logic        dig_last,
    output logic        dig_valid,
    input  logic        dig_ready,
    output logic        busy,
    output logic        err,
    output logic [31:0] write_addr,
    output logic [2:0]  write_prot,
    output logic        write_addr_valid,
    input  logic        write_addr_ready,
    output logic [31:0] write_data,
    output logic [3:0]  write_strb,
    output logic        write_data_valid,
    input  logic        write_data_ready,
    input  logic [1:0]  write_resp,
    input  logic        write_resp_valid,
    output logic        write_resp_ready,
    output logic [31:0] read_addr,
    output logic [2:0]  read_prot,
    output logic        read_addr_valid,
    input  logic        read_addr_ready,
    input  logic [31:0] read_data,
    input  logic [1:0]  read_resp,
    input  logic        read_data_valid,
    output logic        read_data_ready
);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR, S_WRESP, S_CTRL_SET, S_CTRL_CLR, S_POLL, S_DIG_RD, S_DIG_OUT
    } state_t;

    // Remembers which write is in flight so WRESP knows where to return.
    typedef enum logic [1:0] {K_BLOCK, K_SET, K_CLR} wkind_t;

    state_t        r_state, w_state;
    wkind_t        r_kind, w_kind;
    logic [3:0]    r_cnt, w_cnt;
    logic [PW-1:0] r_poll, w_poll;
    logic          r_first, w_first;
    logic          r_aw_done, w_aw_done, r_w_done, w_w_done;
    logic          r_awvalid, w_awvalid, r_wvalid, w_wvalid, r_bready, w_bready;
    logic          r_arvalid, w_arvalid, r_rready, w_rready;
    logic [31:0]   r_waddr, w_waddr, r_wdata, w_wdata, r_raddr, w_raddr;
    logic [31:0]   r_dig_word, w_dig_word;
    logic          r_dig_valid, w_dig_valid, r_dig_last, w_dig_last;
    logic          r_in_ready, w_in_ready, r_busy, w_busy, r_err, w_err;

    always_comb begin
        w_state     = r_state;
        w_kind      = r_kind;
        w_cnt       = r_cnt;
        w_poll      = r_poll;
        w_first     = r_first;
        w_aw_done   = r_aw_done;
        w_w_done    = r_w_done;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_bready    = r_bready;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_waddr     = r_waddr;
        w_wdata     = r_wdata;
        w_raddr     = r_raddr;
        w_dig_word  = r_dig_word;
        w_dig_valid = r_dig_valid;
        w_dig_last  = r_dig_last;
        w_err       = r_err;

        case (r_state)
            S_IDLE: begin
                w_cnt = 4'd0;
                if (in_valid && !r_err) w_state = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_wdata   = in_word;
                    w_waddr   = ADDR_BLOCK + {26'd0, r_cnt, 2'b00};
                    if (r_cnt == 4'd0) w_first = in_first;
                    w_kind    = K_BLOCK;
                    w_awvalid = 1'b1;
                    w_wvalid  = 1'b1;
                    w_aw_done = 1'b0;
                    w_w_done  = 1'b0;
                    w_state   = S_WR;
                end
            end
            S_WR: begin
                // AW and W complete independently; wait for both before B.
                if (r_awvalid && write_addr_ready) begin
                    w_awvalid = 1'b0;
                    w_aw_done = 1'b1;
                end
                if (r_wvalid && write_data_ready) begin
                    w_wvalid = 1'b0;
                    w_w_done = 1'b1;
                end
                if (w_aw_done && w_w_done) begin
                    w_bready = 1'b1;
                    w_state  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (r_bready && write_resp_valid) begin
                    w_bready = 1'b0;
                    if (write_resp != 2'b00) begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        case (r_kind)
                            K_BLOCK: begin
                                if (r_cnt == 4'd15) begin
                                    w_cnt   = 4'd0;
                                    w_state = S_CTRL_SET;
                                end else begin
                                    w_cnt   = r_cnt + 4'd1;
                                    w_state = S_LOAD;
                                end
                            end
                            K_SET:   w_state = S_CTRL_CLR;
                            default: begin
                                w_arvalid = 1'b1;
                                w_raddr   = ADDR_STATUS;
                                w_poll    = PW'(1);
                                w_state   = S_POLL;
                            end
                        endcase
                    end
                end
            end
            S_CTRL_SET, S_CTRL_CLR: begin
                // mode bit stays set; init on the first block, next otherwise
                w_waddr   = ADDR_CTRL;
                w_wdata   = (r_state == S_CTRL_CLR) ? 32'h4 : (r_first ? 32'h5 : 32'h6);
                w_kind    = (r_state == S_CTRL_CLR) ? K_CLR : K_SET;
                w_awvalid = 1'b1;
                w_wvalid  = 1'b1;
                w_aw_done = 1'b0;
                w_w_done  = 1'b0;
                w_state   = S_WR;
            end
            S_POLL, S_DIG_RD: begin
                if (r_arvalid && read_addr_ready) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                end
                if (r_rready && read_data_valid) begin
                    w_rready = 1'b0;
                    if (read_resp != 2'b00) begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end else if (r_state == S_DIG_RD) begin
                        w_dig_word  = read_data;
                        w_dig_valid = 1'b1;
                        w_dig_last  = (r_cnt == 4'd7);
                        w_state     = S_DIG_OUT;
                    end else if (read_data[1]) begin
                        w_cnt     = 4'd0;
                        w_arvalid = 1'b1;
                        w_raddr   = ADDR_DIGEST;
                        w_state   = S_DIG_RD;
                    end else if (r_poll == PW'(POLL_LIMIT)) begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_arvalid = 1'b1;
                        w_poll    = r_poll + PW'(1);
                    end
                end
            end
            S_DIG_OUT: begin
                if (r_dig_valid && dig_ready) begin
                    w_dig_valid = 1'b0;
                    w_dig_last  = 1'b0;
                    if (r_cnt == 4'd7) begin
                        w_cnt   = 4'd0;
                        w_state = S_IDLE;
                    end else begin
                        w_cnt     = r_cnt + 4'd1;
                        w_arvalid = 1'b1;
                        w_raddr   = ADDR_DIGEST + {26'd0, w_cnt, 2'b00};
                        w_state   = S_DIG_RD;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Registered from the next state so they line up with the state itself.
        w_in_ready = (w_state == S_LOAD) && !w_err;
        w_busy     = (w_state != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_kind      <= K_BLOCK;
            r_cnt       <= 4'd0;
            r_poll      <= '0;
            r_first     <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_waddr     <= 32'd0;
            r_wdata     <= 32'd0;
            r_raddr     <= 32'd0;
            r_dig_word  <= 32'd0;
            r_dig_valid <= 1'b0;
            r_dig_last  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_kind      <= w_kind;
            r_cnt       <= w_cnt;
            r_poll      <= w_poll;
            r_first     <= w_first;
            r_aw_done   <= w_aw_done;
            r_w_done    <= w_w_done;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_waddr     <= w_waddr;
            r_wdata     <= w_wdata;
            r_raddr     <= w_raddr;
            r_dig_word  <= w_dig_word;
            r_dig_valid <= w_dig_valid;
            r_dig_last  <= w_dig_last;
            r_in_ready  <= w_in_ready;
            r_busy      <= w_busy;
            r_err       <= w_err;
        end
    end

    assign in_ready         = r_in_ready;
    assign dig_word         = r_dig_word;
    assign dig_last         = r_dig_last;
    assign dig_valid        = r_dig_valid;
    assign busy             = r_busy;
    assign err              = r_err;
    assign write_addr       = r_waddr;
    assign write_prot       = 3'd0;
    assign write_addr_valid = r_awvalid;
    assign write_data       = r_wdata;
    assign write_strb       = 4'hF;
    assign write_data_valid = r_wvalid;
    assign write_resp_ready = r_bready;
    assign read_addr        = r_raddr;
    assign read_prot        = 3'd0;
    assign read_addr_valid  = r_arvalid;
    assign read_data_ready  = r_rready;
endmodule

// File: tb/tb_sha256_axi_sequencer.sv
// Directed bench for sha256_axi_sequencer. An AXI4-Lite slave model stands in
// for the SHA-256 IP. It logs every completed write. It reports digest_valid
// on the third status read after a control write. It returns a preset digest.
module tb_sha256_axi_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_word = '0;
    logic        in_first = 1'b0, in_valid = 1'b0, in_ready;
    logic [31:0] dig_word;
    logic        dig_last, dig_valid, dig_ready = 1'b0, busy, err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    sha256_axi_sequencer #(.POLL_LIMIT(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_word(in_word), .in_first(in_first), .in_valid(in_valid), .in_ready(in_ready),
        .dig_word(dig_word), .dig_last(dig_last), .dig_valid(dig_valid), .dig_ready(dig_ready),
        .busy(busy), .err(err),
        .write_addr(awaddr), .write_prot(awprot), .write_addr_valid(awvalid), .write_addr_ready(awready),
        .write_data(wdata), .write_strb(wstrb), .write_data_valid(wvalid), .write_data_ready(wready),
        .write_resp(bresp), .write_resp_valid(bvalid), .write_resp_ready(bready),
        .read_addr(araddr), .read_prot(arprot), .read_addr_valid(arvalid), .read_addr_ready(arready),
        .read_data(rdata), .read_resp(rresp), .read_data_valid(rvalid), .read_data_ready(rready)
    );

    // ---------------- bench controls (written only by the initial block)
    bit          stall = 1'b0;
    bit          never_ready = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    logic [31:0] exp_dig[8];

    // ---------------- slave model state (written only by the slave process)
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          aw_got = 0, w_got = 0, ar_got = 0;
    logic [31:0] aw_a = '0, w_d = '0, ar_a = '0;
    logic [31:0] log_a[512], log_d[512];
    int          log_n = 0, st_reads = 0, st_since = 0;

    function automatic int dly();
        return stall ? int'($urandom_range(5, 0)) : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        end else begin
            if (awready && awvalid) begin
                aw_got = 1; aw_a = awaddr; awready <= 1'b0;
            end else if (awvalid && !aw_got && !awready && awaddr != hold_addr) begin
                if (aw_dly == 0) awready <= 1'b1; else aw_dly--;
            end
            if (wready && wvalid) begin
                w_got = 1; w_d = wdata; wready <= 1'b0;
            end else if (wvalid && !w_got && !wready) begin
                if (w_dly == 0) wready <= 1'b1; else w_dly--;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got = 0; w_got = 0;
                aw_dly = dly(); w_dly = dly(); b_dly = dly();
            end else if (aw_got && w_got && !bvalid) begin
                if (b_dly == 0) begin
                    bvalid <= 1'b1;
                    bresp  <= (aw_a == err_addr) ? 2'b10 : 2'b00;
                    log_a[log_n % 512] = aw_a;
                    log_d[log_n % 512] = w_d;
                    log_n++;
                    if (aw_a == 32'd4) st_since = 0;
                end else b_dly--;
            end
            if (arready && arvalid) begin
                ar_got = 1; ar_a = araddr; arready <= 1'b0; r_dly = dly();
                if (araddr == 32'd8) begin st_reads++; st_since++; end
            end else if (arvalid && !ar_got && !arready) begin
                if (ar_dly == 0) arready <= 1'b1; else ar_dly--;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got = 0; ar_dly = dly();
            end else if (ar_got && !rvalid) begin
                if (r_dly == 0) begin
                    rvalid <= 1'b1;
                    rresp  <= 2'b00;
                    if (ar_a == 32'd8)
                        rdata <= {30'd0, (!never_ready && st_since >= 3), 1'b1};
                    else if (ar_a >= 32'd84 && ar_a < 32'd116)
                        rdata <= exp_dig[(ar_a - 32'd84) >> 2];
                    else
                        rdata <= 32'hDEAD_BEEF;
                end else r_dly--;
            end
        end
    end

    // ---------------- checking helpers
    int total = 0, bad = 0;
    logic [31:0] blk[16];
    logic [31:0] got_w[8];
    logic        got_l[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic f, output bit ok);
        in_word = w; in_first = f; in_valid = 1'b1; ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic f);
        bit ok;
        bit all_ok = 1;
        for (int i = 0; i < 16; i++) begin
            send_word(blk[i], f, ok);
            all_ok &= ok;
        end
        chk("block_accept", {31'd0, all_ok}, 32'd1);
        $display("block sent first=%0d", f);
    endtask

    task automatic get_digest(input bit check);
        int n = 0;
        dig_ready = 1'b1;
        for (int c = 0; c < 3000 && n < 8; c++) begin
            @(posedge clk);
            if (dig_valid) begin got_w[n] = dig_word; got_l[n] = dig_last; n++; end
        end
        @(negedge clk);
        dig_ready = 1'b0;
        chk("dig_count", n, 8);
        if (check) begin
            for (int i = 0; i < 8; i++) begin
                $display("digest word %0d = %h last=%0d", i, got_w[i], got_l[i]);
                chk("dig_word", got_w[i], exp_dig[i]);
                chk("dig_last", {31'd0, got_l[i]}, (i == 7) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic chk_writes(input int base, input logic [31:0] ctrl_set);
        for (int i = 0; i < 16; i++) begin
            chk("wr_addr", log_a[(base + i) % 512], 32'(20 + 4 * i));
            chk("wr_data", log_d[(base + i) % 512], blk[i]);
        end
        chk("ctrl_set_addr", log_a[(base + 16) % 512], 32'd4);
        chk("ctrl_set_data", log_d[(base + 16) % 512], ctrl_set);
        chk("ctrl_clr_addr", log_a[(base + 17) % 512], 32'd4);
        chk("ctrl_clr_data", log_d[(base + 17) % 512], 32'd4);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0] = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
        exp_dig = '{32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
                    32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD};
    endtask

    task automatic run_abc();
        int base;
        load_abc();
        base = log_n;
        send_block(1'b1);
        get_digest(1'b1);
        chk("write_count", log_n - base, 18);
        chk_writes(base, 32'h5);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dig_valid", {31'd0, dig_valid}, 32'd0);
        chk("rst_dig_word", dig_word, 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int base, st0, highs, c;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_dig_valid", {31'd0, dig_valid}, 32'd0);
        chk("reset_dig_last", {31'd0, dig_last}, 32'd0);
        chk("reset_awvalid", {31'd0, awvalid}, 32'd0);
        chk("reset_arvalid", {31'd0, arvalid}, 32'd0);
        chk("reset_bready", {31'd0, bready}, 32'd0);
        chk("reset_awaddr", awaddr, 32'd0);
        chk("reset_wdata", wdata, 32'd0);
        chk("reset_araddr", araddr, 32'd0);
        chk("reset_dig_word", dig_word, 32'd0);
        chk("strb", {28'd0, wstrb}, 32'hF);
        chk("prot", {26'd0, awprot, arprot}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // "abc" single block, zero-wait slave
        $display("test abc");
        run_abc();

        // Two-block message: second block must use the "next" control value
        $display("test two-block");
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
        exp_dig = '{32'h248D6A61, 32'hD20638B8, 32'hE5C02693, 32'h0C3E6039,
                    32'hA33CE459, 32'h64FF2167, 32'hF6ECEDD4, 32'h19DB06C1};
        base = log_n;
        send_block(1'b1);
        get_digest(1'b0);
        chk_writes(base, 32'h5);
        for (int i = 0; i < 15; i++) blk[i] = 32'd0;
        blk[15] = 32'h0000_01C0;
        base = log_n;
        send_block(1'b0);
        get_digest(1'b1);
        chk_writes(base, 32'h6);

        // Stalling slave
        $display("test stall");
        stall = 1'b1;
        run_abc();
        stall = 1'b0;

        // SLVERR on block word 7
        $display("test slverr");
        load_abc();
        err_addr = 32'd48;
        base = log_n;
        for (int i = 0; i < 8; i++) send_word(blk[i], 1'b1, ok);
        repeat (10) @(negedge clk);
        chk("slverr_err", {31'd0, err}, 32'd1);
        chk("slverr_busy", {31'd0, busy}, 32'd0);
        chk("slverr_writes", log_n - base, 8);
        in_valid = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) highs++;
        end
        in_valid = 1'b0;
        chk("slverr_in_ready_stuck", highs, 0);
        chk("slverr_err_sticky", {31'd0, err}, 32'd1);
        err_addr = 32'hFFFF_FFFF;
        pulse_reset();

        // Status never reports digest_valid
        $display("test poll limit");
        never_ready = 1'b1;
        st0 = st_reads;
        load_abc();
        send_block(1'b1);
        c = 0;
        while (!err && c < 3000) begin @(negedge clk); c++; end
        chk("poll_err", {31'd0, err}, 32'd1);
        chk("poll_reads", st_reads - st0, 16);
        chk("poll_busy", {31'd0, busy}, 32'd0);
        never_ready = 1'b0;
        pulse_reset();

        // Reset during word 9's AW wait
        $display("test reset in aw wait");
        load_abc();
        hold_addr = 32'd56;
        for (int i = 0; i < 10; i++) send_word(blk[i], 1'b1, ok);
        c = 0;
        while (!(awvalid && awaddr == 32'd56) && c < 200) begin @(negedge clk); c++; end
        chk("aw9_waiting", {31'd0, awvalid}, 32'd1);
        repeat (3) @(negedge clk);
        chk("aw9_held", {31'd0, awvalid}, 32'd1);
        pulse_reset();
        hold_addr = 32'hFFFF_FFFF;
        run_abc();

        // Reset while dig_ready is held low
        $display("test reset in dig_out");
        load_abc();
        send_block(1'b1);
        c = 0;
        while (!dig_valid && c < 2000) begin @(negedge clk); c++; end
        repeat (4) @(negedge clk);
        chk("dig_hold_valid", {31'd0, dig_valid}, 32'd1);
        chk("dig_hold_word", dig_word, exp_dig[0]);
        pulse_reset();
        run_abc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
